vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 93 +++++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync and display-enable decode,
// line/frame start pulses and a completed-frame counter, all gated by pix_ce.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        frame_count_d = frame_count_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d       = '0;
                line_start_d = 1'b1;
                if (vcnt_q == V_LAST) begin
                    vcnt_d        = '0;
                    frame_start_d = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_count_q <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_count_q <= frame_count_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Sync and enable decode straight from the counters, so position and timing never skew.
    assign DrawX       = hcnt_q;
    assign DrawY       = vcnt_q;
    assign blank       = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
    assign hs          = !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
    assign vs          = !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance for line timing and a
// reduced-size instance for whole-frame, random-enable, reset and wrap checks.
module tb_vga_timing_gen;

    localparam int SM_HA = 16, SM_HFP = 4, SM_HS = 6, SM_HBP = 6;
    localparam int SM_VA = 12, SM_VFP = 2, SM_VS = 3, SM_VBP = 4;
    localparam int SM_HT = SM_HA + SM_HFP + SM_HS + SM_HBP;
    localparam int SM_VT = SM_VA + SM_VFP + SM_VS + SM_VBP;
    localparam int SM_FT = SM_HT * SM_VT;

    logic vga_clk = 1'b0;
    logic reset_n;
    logic ce_big, ce_sm;

    logic [9:0]  b_x, b_y, s_x, s_y;
    logic        b_blank, b_hs, b_vs, b_ls, b_fs;
    logic        s_blank, s_hs, s_vs, s_ls, s_fs;
    logic [15:0] b_fc, s_fc;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut_big (
        .vga_clk(vga_clk), .reset_n(reset_n), .pix_ce(ce_big),
        .DrawX(b_x), .DrawY(b_y), .blank(b_blank), .hs(b_hs), .vs(b_vs),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(SM_HA), .H_FP(SM_HFP), .H_SYNC(SM_HS), .H_BP(SM_HBP),
        .V_ACTIVE(SM_VA), .V_FP(SM_VFP), .V_SYNC(SM_VS), .V_BP(SM_VBP)
    ) dut_sm (
        .vga_clk(vga_clk), .reset_n(reset_n), .pix_ce(ce_sm),
        .DrawX(s_x), .DrawY(s_y), .blank(s_blank), .hs(s_hs), .vs(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference: the raster position is just the number of enabled edges modulo the frame size.
    int m_pos    = 0;
    int m_frames = 0;
    bit m_ls     = 1'b0;
    bit m_fs     = 1'b0;
    logic [40:0] exp_q[$];

    function automatic logic [40:0] sm_expect();
        int x, y;
        logic bl, h, v;
        x  = m_pos % SM_HT;
        y  = m_pos / SM_HT;
        bl = (x < SM_HA) && (y < SM_VA);
        h  = !((x >= SM_HA + SM_HFP) && (x < SM_HA + SM_HFP + SM_HS));
        v  = !((y >= SM_VA + SM_VFP) && (y < SM_VA + SM_VFP + SM_VS));
        return {10'(x), 10'(y), bl, h, v, m_ls, m_fs, 16'(m_frames)};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_frames = 0; m_ls = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_step(input logic ce);
        if (ce) begin
            m_pos = (m_pos + 1) % SM_FT;
            m_ls  = (m_pos % SM_HT) == 0;
            m_fs  = (m_pos == 0);
            if (m_fs) m_frames = m_frames + 1;
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
        exp_q.push_back(sm_expect());
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, req);
        end
    endtask

    task automatic check_sm();
        logic [40:0] e;
        e = exp_q.pop_front();
        check("sm_outputs", 64'({s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_fc}), 64'(e));
    endtask

    task automatic tick(input logic cb, input logic cs);
        ce_big = cb;
        ce_sm  = cs;
        @(posedge vga_clk);
        model_step(cs);
        @(negedge vga_clk);
        cyc++;
        check_sm();
    endtask

    typedef struct {
        int         n;
        logic       ce;
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       ls;
    } line_vec_t;

    line_vec_t tbl[12];

    initial begin
        int hs_low, blank_low, blank_cnt, vs_low, fs_cnt, guard;
        int fs_times[$];

        tbl[0]  = '{0,   1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1,   1'b1, 10'd1,   10'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1,   1'b0, 10'd1,   10'd0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{638, 1'b1, 10'd639, 10'd0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1,   1'b1, 10'd640, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{15,  1'b1, 10'd655, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1,   1'b1, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{95,  1'b1, 10'd751, 10'd0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1,   1'b1, 10'd752, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{47,  1'b1, 10'd799, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1,   1'b1, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1,   1'b0, 10'd0,   10'd1, 1'b1, 1'b1, 1'b0};

        // Reset values while held in reset, before any clock activity matters.
        reset_n = 1'b0;
        ce_big  = 1'b1;
        ce_sm   = 1'b1;
        #12;
        check("rst_big", 64'({b_x, b_y, b_blank, b_hs, b_vs, b_ls, b_fs, b_fc}),
              64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}));
        check("rst_sm", 64'({s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_fc}),
              64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}));
        @(negedge vga_clk);
        reset_n = 1'b1;
        model_reset();

        // One full default-size line, walked through its boundaries.
        hs_low = 0; blank_low = 0;
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                tick(tbl[i].ce, 1'b0);
                if (!b_hs) hs_low++;
                if (!b_blank) blank_low++;
            end
            check($sformatf("line_vec%0d", i), 64'({b_x, b_y, b_blank, b_hs, b_vs, b_ls}),
                  64'({tbl[i].x, tbl[i].y, tbl[i].blank, tbl[i].hs, 1'b1, tbl[i].ls}));
        end
        check("hs_low_cycles", 64'(hs_low), 64'd96);
        check("blank_low_cycles", 64'(blank_low), 64'd160);

        // Whole small frame with continuous enable.
        blank_cnt = 0; vs_low = 0; fs_cnt = 0;
        for (int k = 0; k < SM_FT; k++) begin
            tick(1'b0, 1'b1);
            if (s_blank) blank_cnt++;
            if (!s_vs) vs_low++;
            if (s_fs) fs_cnt++;
        end
        check("frame_blank_cnt", 64'(blank_cnt), 64'(SM_HA * SM_VA));
        check("frame_vs_low", 64'(vs_low), 64'(SM_VS * SM_HT));
        check("frame_fs_cnt", 64'(fs_cnt), 64'd1);
        check("frame_end_pos", 64'({s_x, s_y, s_fc}), 64'({10'd0, 10'd0, 16'd1}));

        // Random enable pattern against the reference.
        for (int k = 0; k < 3000; k++)
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));

        // Half-rate enable: frame period doubles.
        for (int k = 0; k < 3 * 2 * SM_FT; k++) begin
            tick(1'b0, k[0] == 1'b0);
            if (s_fs) fs_times.push_back(cyc);
        end
        check("halfrate_fs_seen", 64'(fs_times.size() >= 2), 64'd1);
        if (fs_times.size() >= 2)
            check("halfrate_period", 64'(fs_times[1] - fs_times[0]), 64'(2 * SM_FT));

        // Asynchronous reset mid-frame.
        guard = 0;
        while (m_pos != 9 * SM_HT + 22 && guard < 2 * SM_FT) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        check("reach_mid_frame", 64'({s_x, s_y}), 64'({10'd22, 10'd9}));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_sm", 64'({s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_fc}),
              64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0}));
        @(negedge vga_clk);
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("first_edge_after_rst", 64'({s_x, s_y, s_fs}), 64'({10'd1, 10'd0, 1'b0}));

        // Frame counter roll-over from 0xFFFF.
        guard = 0;
        while (m_pos != 0 && guard < 2 * SM_FT) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        force dut_sm.frame_count_q = 16'hFFFF;
        #1;
        release dut_sm.frame_count_q;
        m_frames = 16'hFFFF;
        check("fc_preload", 64'(s_fc), 64'hFFFF);
        fs_cnt = 0;
        for (int k = 0; k < SM_FT; k++) begin
            tick(1'b0, 1'b1);
            if (s_fs) fs_cnt++;
        end
        check("fc_wrap", 64'({s_fc, s_fs}), 64'({16'h0000, 1'b1}));
        tick(1'b0, 1'b1);
        check("fs_one_cycle", 64'({s_fs, s_ls}), 64'd0);
        check("wrap_fs_cnt", 64'(fs_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
